// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - two-client I/D-cache line arbiter in front of the cacheline adaptor
// Grants one cache at a time and holds its registered command until the adaptor responds.
module cache_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 256,
  parameter int RR_EN   = 1,
  parameter int TMO_CYC = 4096
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              m_read,
  output logic              m_write,
  output logic [ADDR_W-1:0] m_address,
  output logic [LINE_W-1:0] m_wdata,
  input  logic [LINE_W-1:0] m_rdata,
  input  logic              m_resp,
  output logic              timeout_o
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  localparam int CNT_W = (TMO_CYC > 0) ? $clog2(TMO_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] TMO_MAX  = CNT_W'(TMO_CYC);
  localparam logic [CNT_W-1:0] TMO_LAST = TMO_MAX - CNT_W'(1);

  state_t           state, state_nxt;
  logic             last_d;
  logic             i_req, d_req, any_req, pick_d;
  logic [CNT_W-1:0] tmo_cnt;

  always_comb begin
    i_req     = i_read;
    d_req     = d_read | d_write;
    any_req   = i_req | d_req;
    pick_d    = d_req;
    // On a tie, round-robin hands the grant to whichever client did not have it last
    if (i_req && d_req) pick_d = (RR_EN != 0) ? ~last_d : 1'b1;
    state_nxt = state;
    case (state)
      IDLE:         if (any_req) state_nxt = pick_d ? GNT_D : GNT_I;
      GNT_I, GNT_D: if (m_resp) state_nxt = IDLE;
      default:      state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_d    <= 1'b0;
      m_read    <= 1'b0;
      m_write   <= 1'b0;
      m_address <= '0;
      m_wdata   <= '0;
      tmo_cnt   <= '0;
      timeout_o <= 1'b0;
    end else if (state == IDLE) begin
      if (any_req) begin
        last_d  <= pick_d;
        tmo_cnt <= '0;
        if (pick_d) begin
          m_address <= d_address;
          m_wdata   <= d_wdata;
          m_write   <= d_write;
          m_read    <= ~d_write;
        end else begin
          m_address <= i_address;
          m_write   <= 1'b0;
          m_read    <= 1'b1;
        end
      end
    end else begin
      if (m_resp) begin
        m_read  <= 1'b0;
        m_write <= 1'b0;
      end
      // Saturating grant-age counter; the grant itself is never revoked
      if (TMO_CYC > 0 && tmo_cnt != TMO_MAX) begin
        tmo_cnt <= tmo_cnt + CNT_W'(1);
        if (tmo_cnt == TMO_LAST) timeout_o <= 1'b1;
      end
    end
  end

  assign i_resp  = m_resp & (state == GNT_I);
  assign d_resp  = m_resp & (state == GNT_D);
  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;

endmodule
